// File: rtl/sel_enc_seq.sv
// sel_enc_seq: control sequencer for register-transfer micro-sequences.
// On an accepted start it latches the instruction word and sequence select,
// then steps through T1..T3 emitting one-hot register strobes and datapath
// strobes. It ends in FIN with a one-cycle done pulse.
//
// Ports:
//   clk      system clock, rising edge
//   clr      asynchronous active-low reset
//   start    request a sequence (sampled in IDLE only)
//   op       00 = MOV (Ra <- Rb), 01 = LA (Ra <- Rb + C), others unsupported
//   ir       instruction word: Ra = ir[26:23], Rb = ir[22:19], C = ir[18:0]
//   Rin      register write-enable strobes (one-hot or zero)
//   Rout     register bus-drive strobes (one-hot or zero)
//   BAout    base-address strobe to R0
//   Yin, Zin, Zlowout, Cout, add   datapath strobes
//   c_sign   latched C sign-extended to 32 bits
//   busy     high whenever the sequencer is not idle
//   done     one-cycle pulse at the end of a sequence
//   err      flags an unsupported op; held until the next accepted start
module sel_enc_seq (
  input  logic        clk,
  input  logic        clr,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] ir,
  output logic [15:0] Rin,
  output logic [15:0] Rout,
  output logic        BAout,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        add,
  output logic [31:0] c_sign,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam logic [1:0] OP_MOV = 2'b00;
  localparam logic [1:0] OP_LA  = 2'b01;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T1   = 3'd1,
    T2   = 3'd2,
    T3   = 3'd3,
    FIN  = 3'd4
  } state_t;

  state_t      state_reg, state_next;
  logic [26:0] ir_reg, ir_next;
  logic [1:0]  op_reg, op_next;
  logic [15:0] rin_reg, rin_next;
  logic [15:0] rout_reg, rout_next;
  logic        baout_reg, baout_next;
  logic        yin_reg, yin_next;
  logic        zin_reg, zin_next;
  logic        zlowout_reg, zlowout_next;
  logic        cout_reg, cout_next;
  logic        add_reg, add_next;
  logic        busy_reg, busy_next;
  logic        done_reg, done_next;
  logic        err_reg, err_next;

  // The upper instruction bits carry no meaning for this sequencer.
  logic unused_ir_hi;
  assign unused_ir_hi = ^ir[31:27];

  // Register-number decoders. T1 strobes are registered on the same edge
  // that latches ir, so they decode the live input. The T3 write-back
  // decodes the latched copy.
  logic [15:0] ra_in_dec;
  logic [15:0] rb_in_dec;
  logic [15:0] ra_lat_dec;

  genvar gi;
  generate
    for (gi = 0; gi < 16; gi++) begin : g_dec
      assign ra_in_dec[gi]  = (ir[26:23] == 4'(gi));
      assign rb_in_dec[gi]  = (ir[22:19] == 4'(gi));
      assign ra_lat_dec[gi] = (ir_reg[26:23] == 4'(gi));
    end
  endgenerate

  // Next-state logic. The strobe values computed here belong to the state
  // being entered, so every strobe leaves a flop.
  always_comb begin
    state_next   = state_reg;
    ir_next      = ir_reg;
    op_next      = op_reg;
    err_next     = err_reg;
    rin_next     = '0;
    rout_next    = '0;
    baout_next   = 1'b0;
    yin_next     = 1'b0;
    zin_next     = 1'b0;
    zlowout_next = 1'b0;
    cout_next    = 1'b0;
    add_next     = 1'b0;
    done_next    = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (start) begin
          ir_next    = ir[26:0];
          op_next    = op;
          err_next   = 1'b0;
          state_next = T1;
          case (op)
            OP_MOV: begin
              rout_next = rb_in_dec;
              rin_next  = ra_in_dec;
            end
            OP_LA: begin
              // R0 drives zero under BAout, so Rb = 0 still yields Y = 0.
              rout_next  = rb_in_dec;
              baout_next = 1'b1;
              yin_next   = 1'b1;
            end
            default: ;
          endcase
        end
      end
      T1: begin
        case (op_reg)
          OP_MOV: begin
            state_next = FIN;
            done_next  = 1'b1;
          end
          OP_LA: begin
            state_next = T2;
            cout_next  = 1'b1;
            add_next   = 1'b1;
            zin_next   = 1'b1;
          end
          default: begin
            state_next = FIN;
            done_next  = 1'b1;
            err_next   = 1'b1;
          end
        endcase
      end
      T2: begin
        state_next   = T3;
        zlowout_next = 1'b1;
        rin_next     = ra_lat_dec;
      end
      T3: begin
        state_next = FIN;
        done_next  = 1'b1;
      end
      FIN: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_reg   <= IDLE;
      ir_reg      <= '0;
      op_reg      <= '0;
      rin_reg     <= '0;
      rout_reg    <= '0;
      baout_reg   <= 1'b0;
      yin_reg     <= 1'b0;
      zin_reg     <= 1'b0;
      zlowout_reg <= 1'b0;
      cout_reg    <= 1'b0;
      add_reg     <= 1'b0;
      busy_reg    <= 1'b0;
      done_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      state_reg   <= state_next;
      ir_reg      <= ir_next;
      op_reg      <= op_next;
      rin_reg     <= rin_next;
      rout_reg    <= rout_next;
      baout_reg   <= baout_next;
      yin_reg     <= yin_next;
      zin_reg     <= zin_next;
      zlowout_reg <= zlowout_next;
      cout_reg    <= cout_next;
      add_reg     <= add_next;
      busy_reg    <= busy_next;
      done_reg    <= done_next;
      err_reg     <= err_next;
    end
  end

  assign Rin     = rin_reg;
  assign Rout    = rout_reg;
  assign BAout   = baout_reg;
  assign Yin     = yin_reg;
  assign Zin     = zin_reg;
  assign Zlowout = zlowout_reg;
  assign Cout    = cout_reg;
  assign add     = add_reg;
  assign busy    = busy_reg;
  assign done    = done_reg;
  assign err     = err_reg;

  assign c_sign = {{13{ir_reg[18]}}, ir_reg[18:0]};

endmodule
